if_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the byte-addressed, word-wide instruction memory.
- Owns the PC and issues one read request at a time over a request/ready handshake.
- Presents fetched words to the IF/ID pipeline register through a valid/stall interface with a one-entry skid buffer.
- Handles branch redirects, including discarding an in-flight response.

---
 rtl/if_fetch_ctrl.sv | 146 ++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues single outstanding word reads,
// and feeds the IF/ID register through a valid/stall slot backed by a one-entry skid.
module if_fetch_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned IMEM_BYTES = 28,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rdy,
  input  logic [31:0]       mem_rdata,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              pipe_stall,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              addr_err
);

  localparam logic [ADDR_W-1:0] MEM_END   = ADDR_W'(IMEM_BYTES);
  localparam logic [ADDR_W-1:0] PC_INIT   = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DRAIN} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] drain_addr_reg, drain_addr_next;
  logic              out_valid_reg, out_valid_next;
  logic [31:0]       out_instr_reg, out_instr_next;
  logic [ADDR_W-1:0] out_pc_reg, out_pc_next;
  logic [31:0]       skid_instr_reg, skid_instr_next;
  logic [ADDR_W-1:0] skid_pc_reg, skid_pc_next;
  logic              addr_err_reg, addr_err_next;

  logic              consume;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] branch_aligned;
  logic              branch_bad;
  logic [ADDR_W-1:0] branch_pc;

  assign consume        = out_valid_reg & ~pipe_stall;
  assign pc_seq         = (pc_reg + WORD_STEP == MEM_END) ? '0 : pc_reg + WORD_STEP;
  assign branch_aligned = branch_addr & WORD_MASK;
  assign branch_bad     = (branch_aligned >= MEM_END);
  assign branch_pc      = branch_bad ? '0 : branch_aligned;

  // DRAIN keeps presenting the address of the abandoned request while pc already holds the target
  assign mem_req     = (state_reg == S_FETCH) || (state_reg == S_DRAIN);
  assign mem_addr    = (state_reg == S_DRAIN) ? drain_addr_reg : pc_reg;
  assign instr_valid = out_valid_reg;
  assign instr       = out_instr_reg;
  assign instr_pc    = out_pc_reg;
  assign addr_err    = addr_err_reg;

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    drain_addr_next = drain_addr_reg;
    out_valid_next  = out_valid_reg;
    out_instr_next  = out_instr_reg;
    out_pc_next     = out_pc_reg;
    skid_instr_next = skid_instr_reg;
    skid_pc_next    = skid_pc_reg;
    addr_err_next   = addr_err_reg;

    if (branch_taken) begin
      pc_next        = branch_pc;
      out_valid_next = 1'b0;
      addr_err_next  = addr_err_reg | branch_bad;
      case (state_reg)
        S_FETCH: begin
          if (!mem_rdy) begin
            state_next      = S_DRAIN;
            drain_addr_next = pc_reg;
          end
        end
        S_DRAIN: state_next = S_DRAIN;
        default: state_next = S_FETCH;
      endcase
    end else begin
      case (state_reg)
        S_IDLE: state_next = S_FETCH;
        S_FETCH: begin
          if (consume) begin
            out_valid_next = 1'b0;
          end
          if (mem_rdy) begin
            pc_next = pc_seq;
            if (!out_valid_reg || consume) begin
              out_valid_next = 1'b1;
              out_instr_next = mem_rdata;
              out_pc_next    = pc_reg;
            end else begin
              skid_instr_next = mem_rdata;
              skid_pc_next    = pc_reg;
              state_next      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (consume) begin
            out_instr_next = skid_instr_reg;
            out_pc_next    = skid_pc_reg;
            state_next     = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (mem_rdy) begin
            state_next = S_FETCH;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      pc_reg         <= PC_INIT;
      drain_addr_reg <= '0;
      out_valid_reg  <= 1'b0;
      out_instr_reg  <= '0;
      out_pc_reg     <= '0;
      skid_instr_reg <= '0;
      skid_pc_reg    <= '0;
      addr_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      drain_addr_reg <= drain_addr_next;
      out_valid_reg  <= out_valid_next;
      out_instr_reg  <= out_instr_next;
      out_pc_reg     <= out_pc_next;
      skid_instr_reg <= skid_instr_next;
      skid_pc_reg    <= skid_pc_next;
      addr_err_reg   <= addr_err_next;
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: per-cycle vector table plus hand-written
// sequences for wait-state memory and reset during an outstanding request.
module tb_if_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rdy;
  logic [31:0] mem_rdata;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        pipe_stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        addr_err;

  int n_vec = 0;
  int n_bad = 0;

  if_fetch_ctrl #(.ADDR_W(32), .IMEM_BYTES(28), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
    .branch_taken(branch_taken), .branch_addr(branch_addr), .pipe_stall(pipe_stall),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of instruction memory: a recognisable word per address
  function automatic logic [31:0] dword(input logic [31:0] a);
    return 32'hC0DE_0000 | a;
  endfunction

  typedef struct {
    logic        rdy;
    logic        br;
    logic [31:0] baddr;
    logic        stall;
    logic        ereq;
    logic [31:0] eaddr;
    logic        ev;
    logic [31:0] epc;
    logic        eerr;
  } vec_t;

  vec_t tbl[40];

  function automatic vec_t mk(input logic rdy, input logic br, input logic [31:0] baddr,
                              input logic stall, input logic ereq, input logic [31:0] eaddr,
                              input logic ev, input logic [31:0] epc, input logic eerr);
    vec_t v;
    v.rdy = rdy; v.br = br; v.baddr = baddr; v.stall = stall;
    v.ereq = ereq; v.eaddr = eaddr; v.ev = ev; v.epc = epc; v.eerr = eerr;
    return v;
  endfunction

  task automatic check(input string name, input logic ereq, input logic [31:0] eaddr,
                       input logic ev, input logic [31:0] epc, input logic eerr);
    logic ok;
    ok = (mem_req === ereq) && (instr_valid === ev) && (addr_err === eerr);
    if (ereq) ok = ok && (mem_addr === eaddr);
    if (ev) ok = ok && (instr_pc === epc) && (instr === dword(epc));
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got req=%0b addr=%0h v=%0b pc=%0h instr=%0h err=%0b; want req=%0b addr=%0h v=%0b pc=%0h instr=%0h err=%0b",
               name, mem_req, mem_addr, instr_valid, instr_pc, instr, addr_err,
               ereq, eaddr, ev, epc, dword(epc), eerr);
    end else begin
      $display("ok   %s: req=%0b addr=%0h v=%0b pc=%0h err=%0b",
               name, mem_req, mem_addr, instr_valid, instr_pc, addr_err);
    end
  endtask

  task automatic check_rst(input string name);
    logic ok;
    ok = (mem_req === 1'b0) && (mem_addr === 32'h0) && (instr_valid === 1'b0) &&
         (instr === 32'h0) && (instr_pc === 32'h0) && (addr_err === 1'b0);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got req=%0b addr=%0h v=%0b instr=%0h pc=%0h err=%0b; want all zero",
               name, mem_req, mem_addr, instr_valid, instr, instr_pc, addr_err);
    end else begin
      $display("ok   %s: reset state", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    // rdy, br, baddr, stall | req, addr, valid, pc, err
    tbl[0]  = mk(0, 0, 32'h00, 0,  0, 32'h00, 0, 32'h00, 0);
    tbl[1]  = mk(1, 0, 32'h00, 0,  1, 32'h00, 0, 32'h00, 0);
    tbl[2]  = mk(1, 0, 32'h00, 0,  1, 32'h04, 1, 32'h00, 0);
    tbl[3]  = mk(1, 0, 32'h00, 0,  1, 32'h08, 1, 32'h04, 0);
    tbl[4]  = mk(1, 0, 32'h00, 0,  1, 32'h0C, 1, 32'h08, 0);
    tbl[5]  = mk(1, 0, 32'h00, 0,  1, 32'h10, 1, 32'h0C, 0);
    tbl[6]  = mk(1, 0, 32'h00, 0,  1, 32'h14, 1, 32'h10, 0);
    tbl[7]  = mk(1, 0, 32'h00, 0,  1, 32'h18, 1, 32'h14, 0);
    tbl[8]  = mk(1, 0, 32'h00, 0,  1, 32'h00, 1, 32'h18, 0);
    tbl[9]  = mk(1, 0, 32'h00, 0,  1, 32'h04, 1, 32'h00, 0);
    tbl[10] = mk(1, 0, 32'h00, 0,  1, 32'h08, 1, 32'h04, 0);
    tbl[11] = mk(1, 0, 32'h00, 1,  1, 32'h0C, 1, 32'h08, 0);
    tbl[12] = mk(0, 0, 32'h00, 1,  0, 32'h00, 1, 32'h08, 0);
    tbl[13] = mk(0, 0, 32'h00, 1,  0, 32'h00, 1, 32'h08, 0);
    tbl[14] = mk(0, 0, 32'h00, 1,  0, 32'h00, 1, 32'h08, 0);
    tbl[15] = mk(0, 0, 32'h00, 0,  0, 32'h00, 1, 32'h08, 0);
    tbl[16] = mk(1, 0, 32'h00, 0,  1, 32'h10, 1, 32'h0C, 0);
    tbl[17] = mk(0, 0, 32'h00, 0,  1, 32'h14, 1, 32'h10, 0);
    tbl[18] = mk(1, 0, 32'h00, 0,  1, 32'h14, 0, 32'h00, 0);
    tbl[19] = mk(0, 0, 32'h00, 0,  1, 32'h18, 1, 32'h14, 0);
    tbl[20] = mk(0, 1, 32'h13, 0,  1, 32'h18, 0, 32'h00, 0);
    tbl[21] = mk(0, 0, 32'h00, 0,  1, 32'h18, 0, 32'h00, 0);
    tbl[22] = mk(1, 0, 32'h00, 0,  1, 32'h18, 0, 32'h00, 0);
    tbl[23] = mk(1, 0, 32'h00, 0,  1, 32'h10, 0, 32'h00, 0);
    tbl[24] = mk(0, 0, 32'h00, 1,  1, 32'h14, 1, 32'h10, 0);
    tbl[25] = mk(0, 1, 32'h40, 1,  1, 32'h14, 1, 32'h10, 0);
    tbl[26] = mk(0, 1, 32'h08, 0,  1, 32'h14, 0, 32'h00, 1);
    tbl[27] = mk(1, 0, 32'h00, 0,  1, 32'h14, 0, 32'h00, 1);
    tbl[28] = mk(1, 0, 32'h00, 0,  1, 32'h08, 0, 32'h00, 1);
    tbl[29] = mk(1, 1, 32'h04, 0,  1, 32'h0C, 1, 32'h08, 1);
    tbl[30] = mk(1, 0, 32'h00, 0,  1, 32'h04, 0, 32'h00, 1);
    tbl[31] = mk(0, 0, 32'h00, 0,  1, 32'h08, 1, 32'h04, 1);
    tbl[32] = mk(0, 1, 32'h1C, 0,  1, 32'h08, 0, 32'h00, 1);
    tbl[33] = mk(1, 0, 32'h00, 0,  1, 32'h08, 0, 32'h00, 1);
    tbl[34] = mk(1, 0, 32'h00, 0,  1, 32'h00, 0, 32'h00, 1);
    tbl[35] = mk(1, 0, 32'h00, 1,  1, 32'h04, 1, 32'h00, 1);
    tbl[36] = mk(0, 1, 32'h18, 1,  0, 32'h00, 1, 32'h00, 1);
    tbl[37] = mk(1, 0, 32'h00, 0,  1, 32'h18, 0, 32'h00, 1);
    tbl[38] = mk(0, 0, 32'h00, 0,  1, 32'h00, 1, 32'h18, 1);
    tbl[39] = mk(0, 0, 32'h00, 0,  1, 32'h00, 0, 32'h00, 1);

    rst = 1'b0; mem_rdy = 1'b0; mem_rdata = 32'h0;
    branch_taken = 1'b0; branch_addr = 32'h0; pipe_stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_rst("reset");

    // Table: check this cycle's outputs, then drive this cycle's inputs
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d", i), tbl[i].ereq, tbl[i].eaddr, tbl[i].ev, tbl[i].epc, tbl[i].eerr);
      rst          = 1'b1;
      mem_rdy      = tbl[i].rdy;
      mem_rdata    = tbl[i].rdy ? dword(tbl[i].eaddr) : 32'hDEAD_BEEF;
      branch_taken = tbl[i].br;
      branch_addr  = tbl[i].baddr;
      pipe_stall   = tbl[i].stall;
    end

    // Reset clears sticky addr_err; then 3-cycle-wait memory
    @(negedge clk);
    rst = 1'b0; mem_rdy = 1'b0; branch_taken = 1'b0; pipe_stall = 1'b0;
    @(negedge clk);
    check_rst("reset2");
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      for (int w = 0; w < 3; w++) begin
        @(negedge clk);
        check($sformatf("wait_w%0d_c%0d", k, w), 1'b1, 32'(4 * k),
              (w == 0) && (k > 0), 32'(4 * (k - 1)), 1'b0);
        mem_rdy   = (w == 2);
        mem_rdata = (w == 2) ? dword(32'(4 * k)) : 32'hDEAD_BEEF;
      end
    end

    // Reset while a request is outstanding; a late response must be ignored
    @(negedge clk);
    check("midwait_pre", 1'b1, 32'h18, 1'b1, 32'h14, 1'b0);
    rst = 1'b0; mem_rdy = 1'b0;
    @(negedge clk);
    check_rst("midwait_rst");
    rst = 1'b1; mem_rdy = 1'b1; mem_rdata = dword(32'h18);
    @(negedge clk);
    check("late_rdy", 1'b1, 32'h00, 1'b0, 32'h00, 1'b0);
    mem_rdy = 1'b1; mem_rdata = dword(32'h00);
    @(negedge clk);
    check("restart0", 1'b1, 32'h04, 1'b1, 32'h00, 1'b0);
    mem_rdy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
